// File: rtl/acc_seq_pkg.sv
// Shared opcode, state and decode-class definitions for the
// accumulator sequencer.
package acc_seq_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int OPD_W  = 12;

    localparam logic [3:0] OP_NAD = 4'h0;
    localparam logic [3:0] OP_SHR = 4'h1;
    localparam logic [3:0] OP_SHL = 4'h2;
    localparam logic [3:0] OP_LDI = 4'h3;
    localparam logic [3:0] OP_LD  = 4'h4;
    localparam logic [3:0] OP_ST  = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_HLT = 4'h8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MREAD,
        S_MWRITE,
        S_EXEC,
        S_HALT
    } state_e;

    typedef struct packed {
        logic exec;
        logic mrd;
        logic mwr;
        logic jmp;
        logic cond;
        logic hlt;
        logic ill;
        logic imm;
    } iclass_t;

    typedef struct packed {
        logic nad;
        logic shr;
        logic shl;
        logic lda;
    } alu_ctl_t;

    function automatic logic [3:0] opc_of(input logic [15:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/acc_seq_decode.sv
// Opcode to instruction class and ALU one-hot select.
// Purely combinational; the sequencer gates ctl with its EXEC state.
module acc_seq_decode
    import acc_seq_pkg::*;
(
    input  logic [3:0] opc,
    output iclass_t    cls,
    output alu_ctl_t   ctl
);

    always_comb begin
        cls = '0;
        ctl = '0;
        unique case (opc)
            OP_NAD: begin
                cls.mrd = 1'b1;
                ctl.nad = 1'b1;
            end
            OP_SHR: begin
                cls.exec = 1'b1;
                ctl.shr  = 1'b1;
            end
            OP_SHL: begin
                cls.exec = 1'b1;
                ctl.shl  = 1'b1;
            end
            OP_LDI: begin
                cls.exec = 1'b1;
                cls.imm  = 1'b1;
            end
            OP_LD:  cls.mrd = 1'b1;
            OP_ST:  cls.mwr = 1'b1;
            OP_JZ: begin
                cls.jmp  = 1'b1;
                cls.cond = 1'b1;
            end
            OP_JMP: cls.jmp = 1'b1;
            OP_HLT: cls.hlt = 1'b1;
            default: cls.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/acc_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator datapath.
// Owns PC, IR, MDR and ACC; talks to single-port memory via req/ack.
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       acc_q,
    output logic [15:0]       mdr_q,
    input  logic [15:0]       alu_result,
    input  logic              alu_is_zero,
    output logic              ctl_nad,
    output logic              ctl_shr,
    output logic              ctl_shl,
    output logic              ctl_lda,
    output logic [ADDR_W-1:0] pc_q,
    output logic              halted,
    output logic              illegal
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       mdr_d;
    logic [15:0]       acc_d;
    logic              ill_q, ill_d;

    logic [ADDR_W-1:0] opd;
    iclass_t           cls;
    alu_ctl_t          dctl;
    logic              in_exec;

    assign opd = ir_q[ADDR_W-1:0];

    acc_seq_decode u_decode (
        .opc (opc_of(ir_q)),
        .cls (cls),
        .ctl (dctl)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        acc_d   = acc_q;
        ill_d   = ill_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    cls.exec: state_d = S_EXEC;
                    cls.mrd:  state_d = S_MREAD;
                    cls.mwr:  state_d = S_MWRITE;
                    cls.jmp: begin
                        if (!cls.cond || alu_is_zero) pc_d = opd;
                        state_d = S_FETCH;
                    end
                    cls.hlt:  state_d = S_HALT;
                    cls.ill: begin
                        ill_d   = 1'b1;
                        state_d = S_HALT;
                    end
                    default:  state_d = S_IDLE;
                endcase
            end
            S_MREAD: begin
                if (mem_ack) begin
                    mdr_d = mem_rdata;
                    // NAD needs the ALU; LD loads ACC directly
                    if (dctl.nad) begin
                        state_d = S_EXEC;
                    end else begin
                        acc_d   = mem_rdata;
                        state_d = S_FETCH;
                    end
                end
            end
            S_MWRITE: begin
                if (mem_ack) state_d = S_FETCH;
            end
            S_EXEC: begin
                acc_d   = cls.imm ? 16'(opd) : alu_result;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            ir_q    <= '0;
            mdr_q   <= '0;
            acc_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            acc_q   <= acc_d;
            ill_q   <= ill_d;
        end
    end

    // Request lines follow state only, so they hold steady until ack.
    assign mem_req   = (state_q == S_FETCH) || (state_q == S_MREAD)
                    || (state_q == S_MWRITE);
    assign mem_we    = (state_q == S_MWRITE);
    assign mem_addr  = (state_q == S_FETCH) ? pc_q : opd;
    assign mem_wdata = acc_q;

    assign in_exec = (state_q == S_EXEC);
    assign ctl_nad = in_exec & dctl.nad;
    assign ctl_shr = in_exec & dctl.shr;
    assign ctl_shl = in_exec & dctl.shl;
    assign ctl_lda = in_exec & dctl.lda;

    assign halted  = (state_q == S_HALT);
    assign illegal = ill_q;

endmodule
